// File: rtl/game_if.sv
// game_if: move request/status handshake plus board store bus for game_sequencer
//   new_game, move_valid, move_addr[3:0]  : move requests toward the sequencer
//   move_ready, move_err, cur_player      : turn handshake and status
//   move_count[3:0], game_over, result[1:0]: game progress and outcome
//   gameBoard[17:0]                       : board store readback, cell i = {b[2i], b[2i+1]}
//   mem_addr[3:0], mem_cell[1:0], mem_clr : board store write/clear bus
interface game_if;
   logic        new_game;
   logic        move_valid;
   logic [3:0]  move_addr;
   logic [17:0] gameBoard;
   logic [3:0]  mem_addr;
   logic [1:0]  mem_cell;
   logic        mem_clr;
   logic        move_ready;
   logic        move_err;
   logic        cur_player;
   logic [3:0]  move_count;
   logic        game_over;
   logic [1:0]  result;
   modport slave (
      input  new_game, move_valid, move_addr, gameBoard,
      output mem_addr, mem_cell, mem_clr, move_ready, move_err,
             cur_player, move_count, game_over, result
   );
   modport master (
      output new_game, move_valid, move_addr, gameBoard,
      input  mem_addr, mem_cell, mem_clr, move_ready, move_err,
             cur_player, move_count, game_over, result
   );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: tic-tac-toe turn sequencer and sole write controller of the board store
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   g        : game_if.slave (move handshake, status, board store bus)
module game_sequencer #(
   parameter logic [1:0] P1_CODE  = 2'b11,
   parameter logic [1:0] P2_CODE  = 2'b10,
   parameter bit         FIRST_P2 = 1'b0
) (
   input logic   clk,
   input logic   reset_n,
   game_if.slave g
);
   typedef enum logic [2:0] {CLEAR, TURN, WRITE, CHECK, DONE} state_t;
   state_t      state, state_d;
   logic        cur_player, player_d;
   logic [3:0]  move_count, count_d;
   logic [1:0]  result, result_d;
   logic        move_err, err_d;
   logic [3:0]  hold_addr, hold_d;
   logic [3:0]  lat_addr, lat_d;
   logic [1:0]  code;
   logic [1:0]  cells [16];
   logic [8:0]  own;
   logic        win;
   logic        legal;
   assign code = cur_player ? P2_CODE : P1_CODE;
   // Cells 9..15 read as empty so any 4-bit address indexes safely; legality
   // is decided separately by the range check.
   for (genvar i = 0; i < 16; i++) begin : g_cell
      if (i < 9) begin : g_real
         assign cells[i] = {g.gameBoard[2*i], g.gameBoard[2*i+1]};
         assign own[i]   = cells[i] == code;
      end else begin : g_pad
         assign cells[i] = 2'b00;
      end
   end
   assign win = (&own[2:0]) | (&own[5:3]) | (&own[8:6]) |
                (own[0] & own[3] & own[6]) | (own[1] & own[4] & own[7]) |
                (own[2] & own[5] & own[8]) | (own[0] & own[4] & own[8]) |
                (own[2] & own[4] & own[6]);
   assign legal = (g.move_addr <= 4'd8) && (cells[g.move_addr] == 2'b00);
   always_comb begin
      state_d  = state;
      player_d = cur_player;
      count_d  = move_count;
      result_d = result;
      err_d    = 1'b0;
      hold_d   = hold_addr;
      lat_d    = lat_addr;
      case (state)
         CLEAR: begin
            state_d  = TURN;
            player_d = FIRST_P2;
            count_d  = 4'd0;
            result_d = 2'b00;
         end
         TURN: begin
            if (g.move_valid && legal) begin
               lat_d   = g.move_addr;
               state_d = WRITE;
            end
            err_d = g.move_valid && !legal;
         end
         WRITE: begin
            hold_d  = lat_addr;
            count_d = move_count + 4'd1;
            state_d = CHECK;
         end
         CHECK: begin
            state_d  = (win || move_count == 4'd9) ? DONE : TURN;
            result_d = win ? code : (move_count == 4'd9) ? 2'b01 : result;
            player_d = (win || move_count == 4'd9) ? cur_player : ~cur_player;
         end
         DONE:    err_d   = g.move_valid;
         default: state_d = CLEAR;
      endcase
      // A clear request overrides everything, including a move in the same cycle.
      if (g.new_game) begin
         state_d = CLEAR;
         err_d   = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= CLEAR;
         cur_player <= FIRST_P2;
         move_count <= 4'd0;
         result     <= 2'b00;
         move_err   <= 1'b0;
         hold_addr  <= 4'd0;
         lat_addr   <= 4'd0;
      end else begin
         state      <= state_d;
         cur_player <= player_d;
         move_count <= count_d;
         result     <= result_d;
         move_err   <= err_d;
         hold_addr  <= hold_d;
         lat_addr   <= lat_d;
      end
   end
   // The store writes every cycle, so outside WRITE it rewrites the last
   // written cell with its own current contents.
   assign g.mem_addr   = (state == WRITE) ? lat_addr : hold_addr;
   assign g.mem_cell   = (state == WRITE) ? code : cells[hold_addr];
   assign g.mem_clr    = state == CLEAR;
   assign g.move_ready = state == TURN;
   assign g.game_over  = state == DONE;
   assign g.move_err   = move_err;
   assign g.cur_player = cur_player;
   assign g.move_count = move_count;
   assign g.result     = result;
endmodule
